// File: rtl/reorder_buffer_pkg.sv
// Shared widths and entry type codes for the reorder buffer.
package reorder_buffer_pkg;
    localparam int DATA_LEN    = 32;
    localparam int ADDR_LEN    = 32;
    localparam int REG_LEN     = 5;
    localparam int ROB_LEN_DEF = 4;

    typedef enum logic [1:0] {
        ROB_REG   = 2'd0,
        ROB_STORE = 2'd1,
        ROB_BR    = 2'd2
    } rob_type_e;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, CDB capture, operand forwarding,
// in-order commit and flush on a branch mispredict discovered at commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int ROB_SIZE = 1 << ROB_LEN_DEF,
    localparam int ROB_LEN  = $clog2(ROB_SIZE)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                rob_push,
    input  logic [1:0]          issue_type,
    input  logic [REG_LEN-1:0]  issue_rd,
    input  logic [ADDR_LEN-1:0] issue_pc,
    input  logic                issue_pred,
    output logic                rob_avail,
    output logic [ROB_LEN-1:0]  rob_avail_pos,
    input  logic                rs1_rob_ok,
    input  logic [ROB_LEN-1:0]  rs1_robpos,
    output logic                rs1_rob_flag,
    output logic [DATA_LEN-1:0] rs1_rob_val,
    input  logic                rs2_rob_ok,
    input  logic [ROB_LEN-1:0]  rs2_robpos,
    output logic                rs2_rob_flag,
    output logic [DATA_LEN-1:0] rs2_rob_val,
    input  logic                alu_cdb_flag,
    input  logic [ROB_LEN-1:0]  alu_cdb_pos,
    input  logic [DATA_LEN-1:0] alu_cdb_val,
    input  logic                alu_cdb_jump,
    input  logic [ADDR_LEN-1:0] alu_cdb_target,
    input  logic                lsb_cdb_flag,
    input  logic [ROB_LEN-1:0]  lsb_cdb_pos,
    input  logic [DATA_LEN-1:0] lsb_cdb_val,
    output logic                commit_flag,
    output logic [REG_LEN-1:0]  commit_rd,
    output logic [DATA_LEN-1:0] commit_val,
    output logic [ROB_LEN-1:0]  commit_robpos,
    output logic                commit_store,
    output logic [ROB_LEN-1:0]  commit_store_pos,
    output logic                clear_flag,
    output logic [ADDR_LEN-1:0] clear_pc
);
    localparam logic [ROB_LEN:0] FULL_CNT = (ROB_LEN+1)'(ROB_SIZE);

    logic [ROB_SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [ROB_LEN-1:0]  head_q, head_d, tail_q, tail_d;
    logic [ROB_LEN:0]    count_q, count_d;

    rob_type_e           type_q   [ROB_SIZE];
    logic [REG_LEN-1:0]  rd_q     [ROB_SIZE];
    logic [ADDR_LEN-1:0] pc_q     [ROB_SIZE];
    logic                pred_q   [ROB_SIZE];
    logic [DATA_LEN-1:0] val_q    [ROB_SIZE];
    logic                jump_q   [ROB_SIZE];
    logic [ADDR_LEN-1:0] target_q [ROB_SIZE];

    logic                cflag_q, cflag_d, sflag_q, sflag_d, clr_q, clr_d;
    logic [REG_LEN-1:0]  crd_q, crd_d;
    logic [DATA_LEN-1:0] cval_q, cval_d;
    logic [ROB_LEN-1:0]  cpos_q, cpos_d, spos_q, spos_d;
    logic [ADDR_LEN-1:0] cpc_q, cpc_d;

    logic push_ok, commit_ok, flush, alu_wr, lsb_wr;

    assign rob_avail     = count_q < FULL_CNT;
    assign rob_avail_pos = tail_q;
    assign push_ok   = rdy_in && rob_push && rob_avail;
    assign commit_ok = rdy_in && busy_q[head_q] && ready_q[head_q];
    assign flush     = commit_ok && (type_q[head_q] == ROB_BR) && (jump_q[head_q] != pred_q[head_q]);
    assign alu_wr    = rdy_in && alu_cdb_flag && busy_q[alu_cdb_pos];
    assign lsb_wr    = rdy_in && lsb_cdb_flag && busy_q[lsb_cdb_pos];

    // Same-cycle CDB results win over stored values; ALU beats LSB on a tie.
    function automatic logic [DATA_LEN:0] fwd(input logic ok, input logic [ROB_LEN-1:0] pos);
        if (!ok)                                  return '0;
        if (alu_cdb_flag && alu_cdb_pos == pos)   return {1'b1, alu_cdb_val};
        if (lsb_cdb_flag && lsb_cdb_pos == pos)   return {1'b1, lsb_cdb_val};
        if (ready_q[pos])                         return {1'b1, val_q[pos]};
        return '0;
    endfunction

    always_comb {rs1_rob_flag, rs1_rob_val} = fwd(rs1_rob_ok, rs1_robpos);
    always_comb {rs2_rob_flag, rs2_rob_val} = fwd(rs2_rob_ok, rs2_robpos);

    always_comb begin
        busy_d  = busy_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cflag_d = 1'b0;
        crd_d   = '0;
        cval_d  = '0;
        cpos_d  = '0;
        sflag_d = 1'b0;
        spos_d  = '0;
        clr_d   = 1'b0;
        cpc_d   = '0;
        if (alu_wr) ready_d[alu_cdb_pos] = 1'b1;
        if (lsb_wr) ready_d[lsb_cdb_pos] = 1'b1;
        if (push_ok) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = (issue_type == ROB_STORE);
            tail_d          = tail_q + 1'b1;
        end
        if (commit_ok) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 1'b1;
            case (type_q[head_q])
                ROB_STORE: begin
                    sflag_d = 1'b1;
                    spos_d  = head_q;
                end
                default: begin
                    cflag_d = 1'b1;
                    crd_d   = rd_q[head_q];
                    cval_d  = val_q[head_q];
                    cpos_d  = head_q;
                end
            endcase
            if (flush) begin
                clr_d = 1'b1;
                cpc_d = jump_q[head_q] ? target_q[head_q] : pc_q[head_q] + ADDR_LEN'(4);
            end
        end
        case ({push_ok, commit_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Payload needs no reset: it is only read while the entry is busy/ready.
    always_ff @(posedge clk_in) begin
        if (push_ok && !flush) begin
            type_q[tail_q] <= rob_type_e'(issue_type);
            rd_q[tail_q]   <= issue_rd;
            pc_q[tail_q]   <= issue_pc;
            pred_q[tail_q] <= issue_pred;
            jump_q[tail_q] <= 1'b0;
        end
        if (alu_wr && !flush) begin
            val_q[alu_cdb_pos]    <= alu_cdb_val;
            jump_q[alu_cdb_pos]   <= alu_cdb_jump;
            target_q[alu_cdb_pos] <= alu_cdb_target;
        end
        if (lsb_wr && !flush) val_q[lsb_cdb_pos] <= lsb_cdb_val;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cflag_q <= 1'b0;
            crd_q   <= '0;
            cval_q  <= '0;
            cpos_q  <= '0;
            sflag_q <= 1'b0;
            spos_q  <= '0;
            clr_q   <= 1'b0;
            cpc_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cflag_q <= cflag_d;
            crd_q   <= crd_d;
            cval_q  <= cval_d;
            cpos_q  <= cpos_d;
            sflag_q <= sflag_d;
            spos_q  <= spos_d;
            clr_q   <= clr_d;
            cpc_q   <= cpc_d;
        end
    end

    assign commit_flag      = cflag_q;
    assign commit_rd        = crd_q;
    assign commit_val       = cval_q;
    assign commit_robpos    = cpos_q;
    assign commit_store     = sflag_q;
    assign commit_store_pos = spos_q;
    assign clear_flag       = clr_q;
    assign clear_pc         = cpc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a queue-based program-order model.
module tb_reorder_buffer;
    logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
    logic        rob_push = 1'b0, issue_pred = 1'b0;
    logic [1:0]  issue_type = 2'd0;
    logic [4:0]  issue_rd = 5'd0;
    logic [31:0] issue_pc = 32'd0;
    logic        rob_avail;
    logic [3:0]  rob_avail_pos;
    logic        rs1_rob_ok = 1'b0, rs2_rob_ok = 1'b0;
    logic [3:0]  rs1_robpos = 4'd0, rs2_robpos = 4'd0;
    logic        rs1_rob_flag, rs2_rob_flag;
    logic [31:0] rs1_rob_val, rs2_rob_val;
    logic        alu_cdb_flag = 1'b0, alu_cdb_jump = 1'b0;
    logic [3:0]  alu_cdb_pos = 4'd0;
    logic [31:0] alu_cdb_val = 32'd0, alu_cdb_target = 32'd0;
    logic        lsb_cdb_flag = 1'b0;
    logic [3:0]  lsb_cdb_pos = 4'd0;
    logic [31:0] lsb_cdb_val = 32'd0;
    logic        commit_flag, commit_store, clear_flag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val, clear_pc;
    logic [3:0]  commit_robpos, commit_store_pos;

    reorder_buffer dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_push(rob_push), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred(issue_pred),
        .rob_avail(rob_avail), .rob_avail_pos(rob_avail_pos),
        .rs1_rob_ok(rs1_rob_ok), .rs1_robpos(rs1_robpos),
        .rs1_rob_flag(rs1_rob_flag), .rs1_rob_val(rs1_rob_val),
        .rs2_rob_ok(rs2_rob_ok), .rs2_robpos(rs2_robpos),
        .rs2_rob_flag(rs2_rob_flag), .rs2_rob_val(rs2_rob_val),
        .alu_cdb_flag(alu_cdb_flag), .alu_cdb_pos(alu_cdb_pos), .alu_cdb_val(alu_cdb_val),
        .alu_cdb_jump(alu_cdb_jump), .alu_cdb_target(alu_cdb_target),
        .lsb_cdb_flag(lsb_cdb_flag), .lsb_cdb_pos(lsb_cdb_pos), .lsb_cdb_val(lsb_cdb_val),
        .commit_flag(commit_flag), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_robpos(commit_robpos), .commit_store(commit_store),
        .commit_store_pos(commit_store_pos), .clear_flag(clear_flag), .clear_pc(clear_pc)
    );

    initial forever #5 clk_in = ~clk_in;

    int checks = 0, failures = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", n, got, exp, $time);
        end
    endtask

    // Model: live entries in program order; q[0] is the oldest (head).
    typedef struct {
        logic [3:0]  pos;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic        rdy;
        logic [31:0] val;
        logic        jump;
        logic [31:0] tgt;
    } ent_t;

    ent_t q[$];
    int   mtail = 0;
    logic e_cf = 0, e_cs = 0, e_clr = 0;
    logic [4:0]  e_rd = 0;
    logic [31:0] e_val = 0, e_cpc = 0;
    logic [3:0]  e_pos = 0, e_spos = 0;
    ent_t h, e;
    bit   do_c;

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            q.delete();
            mtail = 0;
            e_cf = 0; e_cs = 0; e_clr = 0; e_rd = 0; e_val = 0; e_cpc = 0; e_pos = 0; e_spos = 0;
        end else begin
            e_cf = 0; e_cs = 0; e_clr = 0; e_rd = 0; e_val = 0; e_cpc = 0; e_pos = 0; e_spos = 0;
            if (rdy_in) begin
                do_c = (q.size() > 0) && q[0].rdy;
                if (do_c) h = q[0];
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i];
                    if (alu_cdb_flag && e.pos == alu_cdb_pos) begin
                        e.rdy = 1; e.val = alu_cdb_val; e.jump = alu_cdb_jump; e.tgt = alu_cdb_target;
                    end
                    if (lsb_cdb_flag && e.pos == lsb_cdb_pos) begin
                        e.rdy = 1; e.val = lsb_cdb_val;
                    end
                    q[i] = e;
                end
                if (rob_push && q.size() < 16) begin
                    e = '{pos: 4'(mtail), typ: issue_type, rd: issue_rd, pc: issue_pc, pred: issue_pred,
                          rdy: (issue_type == 2'd1), val: 0, jump: 0, tgt: 0};
                    q.push_back(e);
                    mtail = (mtail + 1) % 16;
                end
                if (do_c) begin
                    void'(q.pop_front());
                    if (h.typ == 2'd1) begin
                        e_cs = 1; e_spos = h.pos;
                    end else begin
                        e_cf = 1; e_rd = h.rd; e_val = h.val; e_pos = h.pos;
                    end
                    if (h.typ == 2'd2 && h.jump != h.pred) begin
                        e_clr = 1;
                        e_cpc = h.jump ? h.tgt : h.pc + 32'd4;
                        q.delete();
                        mtail = 0;
                    end
                end
            end
        end
    end

    function automatic void lk(input logic ok, input logic [3:0] pos,
                               output bit known, output logic ef, output logic [31:0] ev);
        known = 1; ef = 0; ev = 0;
        if (!ok) return;
        if (alu_cdb_flag && alu_cdb_pos == pos) begin ef = 1; ev = alu_cdb_val; return; end
        if (lsb_cdb_flag && lsb_cdb_pos == pos) begin ef = 1; ev = lsb_cdb_val; return; end
        known = 0;
        foreach (q[i]) if (q[i].pos == pos) begin
            known = 1; ef = q[i].rdy; ev = q[i].rdy ? q[i].val : 32'd0;
        end
    endfunction

    bit          k1, k2;
    logic        f1, f2;
    logic [31:0] v1, v2;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            chk("rst_avail", 32'(rob_avail), 32'd1);
            chk("rst_avail_pos", 32'(rob_avail_pos), 32'd0);
            chk("rst_pulses", 32'({commit_flag, commit_store, clear_flag}), 32'd0);
        end else begin
            chk("m_avail", 32'(rob_avail), 32'(q.size() < 16));
            chk("m_avail_pos", 32'(rob_avail_pos), 32'(mtail));
            chk("m_commit_flag", 32'(commit_flag), 32'(e_cf));
            chk("m_commit_rd", 32'(commit_rd), 32'(e_rd));
            chk("m_commit_val", commit_val, e_val);
            chk("m_commit_robpos", 32'(commit_robpos), 32'(e_pos));
            chk("m_commit_store", 32'(commit_store), 32'(e_cs));
            chk("m_store_pos", 32'(commit_store_pos), 32'(e_spos));
            chk("m_clear_flag", 32'(clear_flag), 32'(e_clr));
            chk("m_clear_pc", clear_pc, e_cpc);
            lk(rs1_rob_ok, rs1_robpos, k1, f1, v1);
            lk(rs2_rob_ok, rs2_robpos, k2, f2, v2);
            if (k1) begin chk("m_rs1_flag", 32'(rs1_rob_flag), 32'(f1)); chk("m_rs1_val", rs1_rob_val, v1); end
            if (k2) begin chk("m_rs2_flag", 32'(rs2_rob_flag), 32'(f2)); chk("m_rs2_val", rs2_rob_val, v2); end
        end
    end

    task automatic tick();
        @(posedge clk_in); #1;
        rob_push = 0; alu_cdb_flag = 0; lsb_cdb_flag = 0; rs1_rob_ok = 0; rs2_rob_ok = 0;
    endtask

    task automatic push(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input logic pr);
        rob_push = 1; issue_type = t; issue_rd = rd; issue_pc = pc; issue_pred = pr;
    endtask

    task automatic alu(input logic [3:0] p, input logic [31:0] v, input logic j, input logic [31:0] t);
        alu_cdb_flag = 1; alu_cdb_pos = p; alu_cdb_val = v; alu_cdb_jump = j; alu_cdb_target = t;
    endtask

    task automatic lsb(input logic [3:0] p, input logic [31:0] v);
        lsb_cdb_flag = 1; lsb_cdb_pos = p; lsb_cdb_val = v;
    endtask

    task automatic do_reset();
        rst_in = 0; tick(); tick(); rst_in = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        #2 rst_in = 0;
        #1;
        chk("reset_avail", 32'(rob_avail), 32'd1);
        chk("reset_avail_pos", 32'(rob_avail_pos), 32'd0);
        chk("reset_commit_flag", 32'(commit_flag), 32'd0);
        chk("reset_clear_flag", 32'(clear_flag), 32'd0);
        tick(); tick(); rst_in = 1;

        // Push and commit a reg-write
        push(2'd0, 5'd5, 32'h0, 0); tick();
        alu(4'd0, 32'h1234, 0, 32'h0); tick();
        tick();
        chk("pc_commit_flag", 32'(commit_flag), 32'd1);
        chk("pc_commit_rd", 32'(commit_rd), 32'd5);
        chk("pc_commit_val", commit_val, 32'h1234);
        chk("pc_commit_robpos", 32'(commit_robpos), 32'd0);
        tick();
        chk("pc_pulse_one_cycle", 32'(commit_flag), 32'd0);

        // Fill, forward, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push(2'd0, 5'(i + 1), 32'(i * 4), 0); tick();
        end
        chk("full_avail", 32'(rob_avail), 32'd0);
        chk("full_avail_pos", 32'(rob_avail_pos), 32'd0);
        push(2'd0, 5'd31, 32'h0, 0); tick();
        rs1_rob_ok = 1; rs1_robpos = 4'd3; rs2_rob_ok = 1; rs2_robpos = 4'd4;
        alu(4'd3, 32'd7, 0, 32'h0);
        #1;
        chk("fwd_rs1_flag", 32'(rs1_rob_flag), 32'd1);
        chk("fwd_rs1_val", rs1_rob_val, 32'd7);
        chk("fwd_rs2_flag", 32'(rs2_rob_flag), 32'd0);
        chk("fwd_rs2_val", rs2_rob_val, 32'd0);
        tick();
        rs1_rob_ok = 1; rs1_robpos = 4'd3;
        #1;
        chk("fwd_stored_val", rs1_rob_val, 32'd7);
        lsb(4'd0, 32'hAA); alu(4'd1, 32'h11, 0, 32'h0); push(2'd0, 5'd20, 32'h0, 0); tick();
        push(2'd0, 5'd20, 32'h0, 0); tick();
        chk("wrap_commit_val", commit_val, 32'hAA);
        chk("wrap_avail", 32'(rob_avail), 32'd1);
        chk("wrap_avail_pos", 32'(rob_avail_pos), 32'd0);
        push(2'd0, 5'd21, 32'h0, 0); tick();
        chk("wrap_push_pos", 32'(rob_avail_pos), 32'd1);
        chk("wrap_commit_robpos", 32'(commit_robpos), 32'd1);
        chk("wrap_commit_val2", commit_val, 32'h11);

        // Asynchronous reset while a pulse is showing
        #2 rst_in = 0;
        #1;
        chk("async_rst_flag", 32'(commit_flag), 32'd0);
        chk("async_rst_avail_pos", 32'(rob_avail_pos), 32'd0);
        tick(); tick(); rst_in = 1;

        // Mispredict taken; younger entries and same-cycle push are dropped
        push(2'd2, 5'd0, 32'h100, 0); tick();
        push(2'd0, 5'd3, 32'h104, 0); tick();
        push(2'd1, 5'd0, 32'h108, 0); tick();
        alu(4'd0, 32'h104, 1, 32'h200); tick();
        push(2'd0, 5'd7, 32'h10C, 0); alu(4'd1, 32'h55, 0, 32'h0); tick();
        chk("mp_clear_flag", 32'(clear_flag), 32'd1);
        chk("mp_clear_pc", clear_pc, 32'h200);
        chk("mp_commit_flag", 32'(commit_flag), 32'd1);
        chk("mp_commit_val", commit_val, 32'h104);
        chk("mp_avail_pos", 32'(rob_avail_pos), 32'd0);
        tick();
        chk("mp_clear_once", 32'(clear_flag), 32'd0);
        tick(); tick(); tick();

        // Mispredict not-taken redirects to pc+4
        push(2'd2, 5'd1, 32'h300, 1); tick();
        alu(4'd0, 32'h304, 0, 32'h999); tick();
        tick();
        chk("nt_clear_flag", 32'(clear_flag), 32'd1);
        chk("nt_clear_pc", clear_pc, 32'h304);
        tick();

        // Correctly predicted branch
        push(2'd2, 5'd0, 32'h400, 1); tick();
        alu(4'd0, 32'h0, 1, 32'h500); tick();
        tick();
        chk("ok_br_clear", 32'(clear_flag), 32'd0);
        chk("ok_br_commit", 32'(commit_flag), 32'd1);

        // Store release
        push(2'd1, 5'd0, 32'h500, 0); tick();
        tick();
        chk("st_commit_store", 32'(commit_store), 32'd1);
        chk("st_store_pos", 32'(commit_store_pos), 32'd1);
        chk("st_no_regwrite", 32'(commit_flag), 32'd0);

        // Stall with a ready head
        push(2'd0, 5'd9, 32'h0, 0); tick();
        alu(4'd2, 32'h99, 0, 32'h0); tick();
        rdy_in = 0; tick();
        chk("stall_no_commit1", 32'(commit_flag), 32'd0);
        tick();
        chk("stall_no_commit2", 32'(commit_flag), 32'd0);
        rdy_in = 1; tick();
        chk("stall_commit", 32'(commit_flag), 32'd1);
        chk("stall_commit_val", commit_val, 32'h99);

        // Continuous store stream wrapping head and tail
        for (int i = 0; i < 40; i++) begin
            push(2'd1, 5'd0, 32'(i * 4), 0);
            if (i % 3 == 0) begin rs1_rob_ok = 1; rs1_robpos = 4'(i); end
            tick();
        end
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
